warp_issue_scheduler: RTL and testbench



---
 rtl/frontend_pkg.sv | 24 ++
 rtl/warp_issue_scheduler_if.sv | 24 ++
 rtl/warp_issue_scheduler_rr_arbiter.sv | 30 +++
 rtl/warp_issue_scheduler.sv | 137 +++++++++++++
 tb/tb_warp_issue_scheduler.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/frontend_pkg.sv
// Shared frontend types, width defaults and a helper that extracts one warp's
// field from a flattened per-warp bus.
package frontend_pkg;

  localparam int NUM_WARPS_DEF = 8;
  localparam int NUM_LANES_DEF = 16;
  localparam int ARCH_LEN_DEF  = 32;
  localparam int OP_BITS_DEF   = 9;
  localparam int INST_BITS_DEF = 64;

  // Widest flattened bus and widest single field flat_slice can handle.
  localparam int FLAT_MAX  = 1024;
  localparam int SLICE_MAX = 64;

  typedef logic [$clog2(NUM_WARPS_DEF)-1:0] warp_id_t;
  typedef logic [NUM_LANES_DEF-1:0]         tmask_t;

  // Field idx of a bus packed as idx*width +: width; the caller truncates.
  function automatic logic [SLICE_MAX-1:0] flat_slice(input logic [FLAT_MAX-1:0] bus,
                                                      input int width, input int idx);
    return SLICE_MAX'(bus >> (width * idx));
  endfunction

endpackage

// File: rtl/warp_issue_scheduler_if.sv
// Registered issue port between the warp scheduler (master) and backend
// dispatch (slave).
interface warp_issue_scheduler_if #(
  parameter int NUM_WARPS = 8,
  parameter int NUM_LANES = 16,
  parameter int ARCH_LEN  = 32,
  parameter int OP_BITS   = 9,
  parameter int INST_BITS = 64
) ();
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic                 issue_valid;
  logic                 issue_ready;
  logic [WW-1:0]        issue_wid;
  logic [ARCH_LEN-1:0]  issue_pc;
  logic [OP_BITS-1:0]   issue_op;
  logic [NUM_LANES-1:0] issue_tmask;
  logic [INST_BITS-1:0] issue_raw;

  modport master (output issue_valid, issue_wid, issue_pc, issue_op, issue_tmask, issue_raw,
                  input  issue_ready);
  modport slave  (input  issue_valid, issue_wid, issue_pc, issue_op, issue_tmask, issue_raw,
                  output issue_ready);
endinterface

// File: rtl/warp_issue_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above
// ptr, wrapping from N-1 to 0.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any
);
  logic [W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = W'((int'(ptr) + i) % N);
      if (req[cand]) begin
        grant_idx = cand;
        any       = 1'b1;
      end
    end
    grant = any ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Picks one eligible warp per cycle (round-robin, credit-limited, stall-masked)
// and loads its ibuf head into the registered issue port.
module warp_issue_scheduler import frontend_pkg::*; #(
  parameter int NUM_WARPS    = NUM_WARPS_DEF,
  parameter int NUM_LANES    = NUM_LANES_DEF,
  parameter int ARCH_LEN     = ARCH_LEN_DEF,
  parameter int OP_BITS      = OP_BITS_DEF,
  parameter int INST_BITS    = INST_BITS_DEF,
  parameter int MAX_INFLIGHT = 4,
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_WARPS-1:0]           ibuf_valid,
  output logic [NUM_WARPS-1:0]           ibuf_ready,
  input  logic [NUM_WARPS*ARCH_LEN-1:0]  ibuf_pc,
  input  logic [NUM_WARPS*OP_BITS-1:0]   ibuf_op,
  input  logic [NUM_WARPS*NUM_LANES-1:0] ibuf_tmask,
  input  logic [NUM_WARPS*INST_BITS-1:0] ibuf_raw,
  input  logic [NUM_WARPS-1:0]           warp_stall,
  warp_issue_scheduler_if.master         issue,
  input  logic                           commit_valid,
  input  logic [WW-1:0]                  commit_wid,
  output logic                           err_underflow
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic                 issue_valid_q, issue_valid_d;
  logic [WW-1:0]        issue_wid_q, issue_wid_d;
  logic [ARCH_LEN-1:0]  issue_pc_q, issue_pc_d;
  logic [OP_BITS-1:0]   issue_op_q, issue_op_d;
  logic [NUM_LANES-1:0] issue_tmask_q, issue_tmask_d;
  logic [INST_BITS-1:0] issue_raw_q, issue_raw_d;
  logic [WW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        inflight_q [NUM_WARPS];
  logic [CW-1:0]        inflight_d [NUM_WARPS];
  logic                 err_underflow_q, err_underflow_d;

  logic                 load;
  logic [NUM_WARPS-1:0] eligible, req, gnt_onehot;
  logic [WW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic [FLAT_MAX-1:0]  pc_flat, op_flat, tmask_flat, raw_flat;

  assign pc_flat    = FLAT_MAX'(ibuf_pc);
  assign op_flat    = FLAT_MAX'(ibuf_op);
  assign tmask_flat = FLAT_MAX'(ibuf_tmask);
  assign raw_flat   = FLAT_MAX'(ibuf_raw);

  // The credit check sees the pre-commit count, so a commit frees a slot next cycle.
  always_comb begin
    load = ~issue_valid_q | issue.issue_ready;
    for (int g = 0; g < NUM_WARPS; g++) begin
      eligible[g] = ibuf_valid[g] & ~warp_stall[g] & (inflight_q[g] < CW'(MAX_INFLIGHT));
    end
    req = load ? eligible : '0;
  end

  rr_arbiter #(.N(NUM_WARPS), .W(WW)) u_arb (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (gnt_onehot),
    .grant_idx (gnt_idx),
    .any       (gnt_any)
  );

  assign ibuf_ready = gnt_onehot;

  always_comb begin
    issue_valid_d   = issue_valid_q;
    issue_wid_d     = issue_wid_q;
    issue_pc_d      = issue_pc_q;
    issue_op_d      = issue_op_q;
    issue_tmask_d   = issue_tmask_q;
    issue_raw_d     = issue_raw_q;
    rr_ptr_d        = rr_ptr_q;
    err_underflow_d = err_underflow_q;

    if (load) begin
      issue_valid_d = gnt_any;
      if (gnt_any) begin
        issue_wid_d   = gnt_idx;
        issue_pc_d    = ARCH_LEN'(flat_slice(pc_flat, ARCH_LEN, int'(gnt_idx)));
        issue_op_d    = OP_BITS'(flat_slice(op_flat, OP_BITS, int'(gnt_idx)));
        issue_tmask_d = NUM_LANES'(flat_slice(tmask_flat, NUM_LANES, int'(gnt_idx)));
        issue_raw_d   = INST_BITS'(flat_slice(raw_flat, INST_BITS, int'(gnt_idx)));
        rr_ptr_d      = WW'((int'(gnt_idx) + 1) % NUM_WARPS);
      end
    end

    // A commit against an empty counter is flagged and ignored, never wrapped.
    for (int g = 0; g < NUM_WARPS; g++) begin
      inflight_d[g] = inflight_q[g];
      if (commit_valid && (commit_wid == WW'(g))) begin
        if (inflight_q[g] == '0) err_underflow_d = 1'b1;
        else                     inflight_d[g]   = inflight_q[g] - CW'(1);
      end
      if (gnt_onehot[g]) inflight_d[g] = inflight_d[g] + CW'(1);
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and wins
  // over any same-cycle grant or commit; the credit array is reset too, since a
  // stale count would permanently block a warp.
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_valid_q   <= 1'b0;
      issue_wid_q     <= '0;
      issue_pc_q      <= '0;
      issue_op_q      <= '0;
      issue_tmask_q   <= '0;
      issue_raw_q     <= '0;
      rr_ptr_q        <= '0;
      err_underflow_q <= 1'b0;
      for (int g = 0; g < NUM_WARPS; g++) inflight_q[g] <= '0;
    end else begin
      issue_valid_q   <= issue_valid_d;
      issue_wid_q     <= issue_wid_d;
      issue_pc_q      <= issue_pc_d;
      issue_op_q      <= issue_op_d;
      issue_tmask_q   <= issue_tmask_d;
      issue_raw_q     <= issue_raw_d;
      rr_ptr_q        <= rr_ptr_d;
      err_underflow_q <= err_underflow_d;
      for (int g = 0; g < NUM_WARPS; g++) inflight_q[g] <= inflight_d[g];
    end
  end

  assign issue.issue_valid = issue_valid_q;
  assign issue.issue_wid   = issue_wid_q;
  assign issue.issue_pc    = issue_pc_q;
  assign issue.issue_op    = issue_op_q;
  assign issue.issue_tmask = issue_tmask_q;
  assign issue.issue_raw   = issue_raw_q;
  assign err_underflow     = err_underflow_q;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Bench for warp_issue_scheduler: directed vector table with hand-derived
// expectations, then random traffic against a cycle-level reference model.
module tb_warp_issue_scheduler;
  import frontend_pkg::*;

  localparam int NW = 8, NL = 16, AL = 32, OB = 9, IB = 64, MAXI = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic [NW-1:0]  ibuf_valid, ibuf_ready, warp_stall;
  logic [NW*AL-1:0] ibuf_pc;
  logic [NW*OB-1:0] ibuf_op;
  logic [NW*NL-1:0] ibuf_tmask;
  logic [NW*IB-1:0] ibuf_raw;
  logic           commit_valid;
  warp_id_t       commit_wid;
  logic           err_underflow;

  logic [AL-1:0] pc_a [NW];
  logic [OB-1:0] op_a [NW];
  logic [NL-1:0] tm_a [NW];
  logic [IB-1:0] raw_a [NW];

  for (genvar g = 0; g < NW; g++) begin : g_flat
    assign ibuf_pc[g*AL +: AL]    = pc_a[g];
    assign ibuf_op[g*OB +: OB]    = op_a[g];
    assign ibuf_tmask[g*NL +: NL] = tm_a[g];
    assign ibuf_raw[g*IB +: IB]   = raw_a[g];
  end

  warp_issue_scheduler_if #(.NUM_WARPS(NW), .NUM_LANES(NL), .ARCH_LEN(AL),
                            .OP_BITS(OB), .INST_BITS(IB)) issue_if ();

  warp_issue_scheduler #(.NUM_WARPS(NW), .NUM_LANES(NL), .ARCH_LEN(AL), .OP_BITS(OB),
                         .INST_BITS(IB), .MAX_INFLIGHT(MAXI)) dut (
    .clock(clock), .reset(reset),
    .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready),
    .ibuf_pc(ibuf_pc), .ibuf_op(ibuf_op), .ibuf_tmask(ibuf_tmask), .ibuf_raw(ibuf_raw),
    .warp_stall(warp_stall), .issue(issue_if),
    .commit_valid(commit_valid), .commit_wid(commit_wid),
    .err_underflow(err_underflow)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: issue slot contents, pointer, per-warp credit counts.
  logic          m_valid = 1'b0, m_err = 1'b0;
  int            m_wid = 0, m_ptr = 0;
  logic [AL-1:0] m_pc = '0;
  logic [OB-1:0] m_op = '0;
  logic [NL-1:0] m_tm = '0;
  logic [IB-1:0] m_raw = '0;
  int            m_cnt [NW] = '{default: 0};

  // One clock: drive inputs with fresh random heads, check ibuf_ready, advance.
  task automatic apply(input logic rst, input logic [NW-1:0] v, input logic [NW-1:0] s,
                       input logic r, input logic cv, input int cw);
    int   gsel;
    logic ld;
    logic [NW-1:0] exp_rdy;
    for (int w = 0; w < NW; w++) begin
      pc_a[w]  = $urandom;
      op_a[w]  = OB'($urandom);
      tm_a[w]  = NL'($urandom);
      raw_a[w] = {$urandom, $urandom};
    end
    reset = rst; ibuf_valid = v; warp_stall = s; issue_if.issue_ready = r;
    commit_valid = cv; commit_wid = warp_id_t'(cw);

    ld = !m_valid || r;
    gsel = -1;
    if (ld) begin
      for (int off = 0; off < NW; off++) begin
        int w;
        w = (m_ptr + off) % NW;
        if (gsel < 0 && v[w] && !s[w] && m_cnt[w] < MAXI) gsel = w;
      end
    end
    exp_rdy = (gsel >= 0) ? NW'(1 << gsel) : '0;
    #1;
    if (!rst) check("ibuf_ready", 64'(ibuf_ready), 64'(exp_rdy));
    @(posedge clock);

    if (rst) begin
      m_valid = 0; m_err = 0; m_wid = 0; m_ptr = 0;
      m_pc = '0; m_op = '0; m_tm = '0; m_raw = '0;
      for (int w = 0; w < NW; w++) m_cnt[w] = 0;
    end else begin
      if (cv) begin
        if (m_cnt[cw] == 0) m_err = 1;
        else m_cnt[cw]--;
      end
      if (ld) begin
        m_valid = (gsel >= 0);
        if (gsel >= 0) begin
          m_wid = gsel; m_ptr = (gsel + 1) % NW; m_cnt[gsel]++;
          m_pc = pc_a[gsel]; m_op = op_a[gsel]; m_tm = tm_a[gsel]; m_raw = raw_a[gsel];
        end
      end
    end
    #1;
    check("issue_valid", 64'(issue_if.issue_valid), 64'(m_valid));
    check("issue_wid",   64'(issue_if.issue_wid),   64'(m_wid));
    check("issue_pc",    64'(issue_if.issue_pc),    64'(m_pc));
    check("issue_op",    64'(issue_if.issue_op),    64'(m_op));
    check("issue_tmask", 64'(issue_if.issue_tmask), 64'(m_tm));
    check("issue_raw",   issue_if.issue_raw,        m_raw);
    check("err_underflow", 64'(err_underflow),      64'(m_err));
  endtask

  typedef struct {
    logic          rst;
    logic [NW-1:0] v, s;
    logic          r, cv;
    int            cw;
    logic          ev;   // expected issue_valid after the edge
    int            ew;   // expected issue_wid when ev
    logic          ee;   // expected err_underflow
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic [NW-1:0] v, logic [NW-1:0] s, logic r,
                              logic cv, int cw, logic ev, int ew, logic ee);
    vecs.push_back('{rst, v, s, r, cv, cw, ev, ew, ee});
  endfunction

  initial begin
    // Reset, then full round-robin until every warp hits its credit limit.
    add(1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0);
    add(1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 36; i++) add(0, 8'hFF, 8'h00, 1, 0, 0, i < 32, i % 8, 0);

    // Stall mask 0F: only 4..7; then warp 1 freed and picked up after the wrap.
    add(1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0);
    add(0, 8'hFF, 8'h0F, 1, 0, 0, 1, 4, 0);
    add(0, 8'hFF, 8'h0F, 1, 0, 0, 1, 5, 0);
    add(0, 8'hFF, 8'h0F, 1, 0, 0, 1, 6, 0);
    add(0, 8'hFF, 8'h0F, 1, 0, 0, 1, 7, 0);
    add(0, 8'hFF, 8'h0F, 1, 0, 0, 1, 4, 0);
    add(0, 8'hFF, 8'h0F, 1, 0, 0, 1, 5, 0);
    add(0, 8'hFF, 8'h0D, 1, 0, 0, 1, 6, 0);
    add(0, 8'hFF, 8'h0D, 1, 0, 0, 1, 7, 0);
    add(0, 8'hFF, 8'h0D, 1, 0, 0, 1, 1, 0);
    add(0, 8'hFF, 8'h0D, 1, 0, 0, 1, 4, 0);
    add(0, 8'hFF, 8'h0D, 1, 0, 0, 1, 5, 0);
    add(0, 8'hFF, 8'h0D, 1, 0, 0, 1, 6, 0);

    // Backpressure with warp 2 held (and stalled meanwhile); release grants 3.
    add(1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0);
    add(0, 8'hFF, 8'h00, 1, 0, 0, 1, 0, 0);
    add(0, 8'hFF, 8'h00, 1, 0, 0, 1, 1, 0);
    add(0, 8'hFF, 8'h00, 1, 0, 0, 1, 2, 0);
    add(0, 8'hFF, 8'h04, 0, 0, 0, 1, 2, 0);
    add(0, 8'hFF, 8'h04, 0, 0, 0, 1, 2, 0);
    add(0, 8'hFF, 8'h04, 0, 0, 0, 1, 2, 0);
    add(0, 8'hFF, 8'h04, 1, 0, 0, 1, 3, 0);

    // Warp 5 credits: commit frees a slot only the cycle after.
    add(1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 8'h20, 8'h00, 1, 0, 0, 1, 5, 0);
    add(0, 8'h20, 8'h00, 1, 0, 0, 0, 0, 0);
    add(0, 8'h20, 8'h00, 1, 1, 5, 0, 0, 0);   // count 4 -> 3, no grant yet
    add(0, 8'h20, 8'h00, 1, 0, 0, 1, 5, 0);   // 3 -> 4
    add(0, 8'h20, 8'h00, 1, 1, 5, 0, 0, 0);   // 4 -> 3
    add(0, 8'h20, 8'h00, 1, 1, 5, 1, 5, 0);   // grant + commit: stays 3
    add(0, 8'h20, 8'h00, 1, 0, 0, 1, 5, 0);   // 3 -> 4
    add(0, 8'h20, 8'h00, 1, 0, 0, 0, 0, 0);   // full

    // Underflow on warp 6 is sticky and leaves its count at 0 (4 grants fit).
    add(0, 8'h00, 8'h00, 1, 1, 6, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 8'h40, 8'h00, 1, 0, 0, 1, 6, 1);
    add(0, 8'h40, 8'h00, 1, 0, 0, 0, 0, 1);
    add(0, 8'hFF, 8'h00, 1, 0, 0, 1, 7, 1);

    // Reset while an issue is held and credits are live; pointer back to 0.
    add(1, 8'hFF, 8'h00, 0, 1, 7, 0, 0, 0);
    add(0, 8'hFF, 8'h00, 1, 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].r, vecs[i].cv, vecs[i].cw);
      check($sformatf("tbl[%0d].valid", i), 64'(issue_if.issue_valid), 64'(vecs[i].ev));
      if (vecs[i].ev)
        check($sformatf("tbl[%0d].wid", i), 64'(issue_if.issue_wid), 64'(vecs[i].ew));
      check($sformatf("tbl[%0d].err", i), 64'(err_underflow), 64'(vecs[i].ee));
    end

    // Random traffic; commits only target warps the model shows as in flight.
    for (int n = 0; n < 3000; n++) begin
      logic          rst, r, cv;
      logic [NW-1:0] v, s;
      int            cw;
      rst = ($urandom_range(0, 399) == 0);
      v   = NW'($urandom);
      s   = ($urandom_range(0, 1) == 0) ? NW'($urandom) : '0;
      r   = ($urandom_range(0, 3) != 0);
      cw  = $urandom_range(0, NW - 1);
      cv  = ($urandom_range(0, 1) == 0) && (m_cnt[cw] > 0);
      apply(rst, v, s, r, cv, cw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
